glyph_line_fetch: RTL

Per-scanline glyph prefetch sequencer. It sits between the text buffer RAM, the character ROM and the pixel line buffer. On each line_start it walks one text row, reading character codes and driving the character ROM address, then writes one glyph byte per column into the line buffer. It applies reverse video (8x8 font) and cursor inversion on the way.

---
 rtl/glyph_line_fetch.sv | 132 +++++++++++++
 1 files changed

// File: rtl/glyph_line_fetch.sv
// Per-scanline glyph prefetch: walks one text row, looks up each glyph row in the
// character ROM and writes one byte per column into the pixel line buffer.
module glyph_line_fetch #(
  parameter int COLS    = 80,
  parameter int TEXT_AW = 11
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               line_start,
  input  logic [TEXT_AW-1:0] row_base,
  input  logic [3:0]         glyph_row,
  input  logic               font_8x8,
  input  logic               cursor_en,
  input  logic [7:0]         cursor_col,
  output logic [TEXT_AW-1:0] text_addr,
  input  logic [7:0]         text_data,
  output logic [11:0]        rom_addr,
  input  logic [7:0]         rom_data,
  output logic               lb_we,
  output logic [7:0]         lb_addr,
  output logic [7:0]         lb_data,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  localparam logic [7:0] LAST_COL = 8'(COLS - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [7:0]         r_col;
  logic               r_drain;
  logic [TEXT_AW-1:0] r_text_addr;
  logic [3:0]         r_glyph_row;
  logic               r_font;
  logic               r_cur_en;
  logic [7:0]         r_cur_col;
  logic               r_s2_valid;
  logic [7:0]         r_s2_col;
  logic               r_s3_valid;
  logic [7:0]         r_s3_col;
  logic               r_s3_inv;
  logic               r_lb_we;
  logic [7:0]         r_lb_addr;
  logic [7:0]         r_lb_data;
  logic               w_inv;
  logic [11:0]        w_rom_addr;

  // A line_start from any state (re)starts the walk from column 0.
  always_comb begin
    w_state_next = r_state;
    if (line_start) begin
      w_state_next = S_FETCH;
    end else begin
      case (r_state)
        S_IDLE:  w_state_next = S_IDLE;
        S_FETCH: if (r_col == LAST_COL) w_state_next = S_DRAIN;
        S_DRAIN: if (r_drain) w_state_next = S_DONE;
        S_DONE:  w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Stage 2: text_data is live this cycle, so the ROM address is formed directly from it.
  always_comb begin
    w_rom_addr = r_font ? {1'b0, text_data[6:0], 1'b0, r_glyph_row[2:0]}
                        : {text_data, r_glyph_row};
    w_inv      = (r_font & text_data[7]) ^ (r_cur_en & (r_s2_col == r_cur_col));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_col       <= '0;
      r_drain     <= 1'b0;
      r_text_addr <= '0;
      r_glyph_row <= '0;
      r_font      <= 1'b0;
      r_cur_en    <= 1'b0;
      r_cur_col   <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_col    <= '0;
      r_s3_valid  <= 1'b0;
      r_s3_col    <= '0;
      r_s3_inv    <= 1'b0;
      r_lb_we     <= 1'b0;
      r_lb_addr   <= '0;
      r_lb_data   <= '0;
    end else begin
      r_state <= w_state_next;
      if (line_start) begin
        r_col       <= '0;
        r_drain     <= 1'b0;
        r_text_addr <= row_base;
        r_glyph_row <= glyph_row;
        r_font      <= font_8x8;
        r_cur_en    <= cursor_en;
        r_cur_col   <= cursor_col;
      end else if (r_state == S_FETCH) begin
        if (r_col != LAST_COL) begin
          r_col       <= r_col + 8'd1;
          r_text_addr <= r_text_addr + 1'b1;
        end
      end else if (r_state == S_DRAIN) begin
        r_drain <= 1'b1;
      end

      // A restart flushes every column still in flight.
      r_s2_valid <= (r_state == S_FETCH) & ~line_start;
      r_s2_col   <= r_col;
      r_s3_valid <= r_s2_valid & ~line_start;
      r_s3_col   <= r_s2_col;
      r_s3_inv   <= w_inv;
      r_lb_we    <= r_s3_valid & ~line_start;
      if (r_s3_valid && !line_start) begin
        r_lb_addr <= r_s3_col;
        r_lb_data <= rom_data ^ {8{r_s3_inv}};
      end
    end
  end

  assign text_addr = r_text_addr;
  assign rom_addr  = r_s2_valid ? w_rom_addr : 12'd0;
  assign lb_we     = r_lb_we;
  assign lb_addr   = r_lb_addr;
  assign lb_data   = r_lb_data;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule
